// File: rtl/imem_loader_pkg.sv
// Shared CPU-side constants and the instruction-memory loader state encoding.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned CHK_W       = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenLo = 3'd1,
    StLenHi = 3'd2,
    StData  = 3'd3,
    StCsum  = 3'd4,
    StDone  = 3'd5,
    StError = 3'd6
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses the cycle
// after the 4th byte of each word is accepted.
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte
);

  logic [1:0]  idx;
  logic [31:0] shreg;
  logic        wv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      shreg <= '0;
      wv    <= 1'b0;
    end else begin
      wv <= byte_en && (idx == 2'd3) && !clear;
      if (clear) begin
        idx <= '0;
      end else if (byte_en) begin
        idx   <= idx + 2'd1;
        // Shifting in from the top leaves the first byte in [7:0] after four bytes.
        shreg <= {byte_in, shreg[31:8]};
      end
    end
  end

  assign word       = shreg;
  assign word_valid = wv;
  assign last_byte  = (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into instruction memory and
// releases the CPU hold only after a clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              im_wen,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_e state, state_next;

  logic [15:0]      len;
  logic [CHK_W-1:0] chk;
  logic [ADDR_W:0]  wcnt;
  logic             hold;

  logic        xfer;
  logic        restart;
  logic        data_byte;
  logic        last_byte;
  logic        last_word;
  logic        len_bad;
  logic [15:0] len_full;
  logic [16:0] wcnt_next;

  assign rx_ready = (state == StLenLo) || (state == StLenHi) ||
                    (state == StData)  || (state == StCsum);
  assign busy     = rx_ready;
  assign done     = (state == StDone);
  assign err      = (state == StError);

  assign xfer      = rx_valid && rx_ready;
  assign restart   = start && ((state == StIdle) || (state == StDone) || (state == StError));
  assign data_byte = xfer && (state == StData);

  assign len_full  = {rx_data, len[7:0]};
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);
  // The previous word's write has always retired by the 4th byte of the next word.
  assign wcnt_next = 17'(wcnt) + 17'd1;
  assign last_word = (wcnt_next == {1'b0, len});

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_en    (data_byte),
    .byte_in    (rx_data),
    .word       (im_wdata),
    .word_valid (im_wen),
    .last_byte  (last_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle, StDone, StError: begin
        if (start) state_next = StLenLo;
      end
      StLenLo: begin
        if (xfer) state_next = StLenHi;
      end
      StLenHi: begin
        if (xfer) begin
          if (len_bad) state_next = StError;
          else         state_next = StData;
        end
      end
      StData: begin
        // The final word's write strobe lands in the first CSUM cycle.
        if (xfer && last_byte && last_word) state_next = StCsum;
      end
      StCsum: begin
        if (xfer) begin
          if (rx_data == chk) state_next = StDone;
          else                state_next = StError;
        end
      end
      default: state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len  <= '0;
      chk  <= '0;
      wcnt <= '0;
      hold <= 1'b1;
    end else begin
      if (xfer && (state == StLenLo)) len[7:0]  <= rx_data;
      if (xfer && (state == StLenHi)) len[15:8] <= rx_data;

      if (restart)        chk <= '0;
      else if (data_byte) chk <= chk ^ rx_data;

      if (restart)     wcnt <= '0;
      else if (im_wen) wcnt <= wcnt + 1'b1;

      if (restart)              hold <= 1'b1;
      else if (state == StDone) hold <= 1'b0;
    end
  end

  assign im_addr      = wcnt[ADDR_W-1:0];
  assign words_loaded = wcnt;
  assign cpu_hold     = hold;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a queue of expected memory writes built from the
// image plus end-of-load checks on done/err/cpu_hold/words_loaded.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        im_wen;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;

  imem_loader #(
    .ADDR_W    (10),
    .MAX_WORDS (1024)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .im_wen       (im_wen),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_wr[$];
  wr_t         e;
  logic [31:0] img [0:1023];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] chk_of(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) c = c ^ img[i][8*k +: 8];
    return c;
  endfunction

  // Every write strobe must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (reset) begin
      if (im_wen === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   im_addr, im_wdata);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(im_addr), 64'(e.addr));
          check("wr_data", 64'(im_wdata), 64'(e.data));
        end
      end
      if (busy === 1'b1) check("hold_while_busy", 64'(cpu_hold), 64'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit sent;
    sent = 1'b0;
    for (int i = 0; i < 64 && !sent; i++) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_data  = b;
        rx_valid = 1'b1;
        if (rx_ready) begin
          @(posedge clk);
          #1;
          rx_valid = 1'b0;
          sent     = 1'b1;
        end
      end
    end
    if (!sent) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte 0x%0h not accepted, expected within 64 cycles", b);
    end
  endtask

  task automatic pulse_start(input bit expect_restart);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_hold", 64'(cpu_hold), 64'd1);
    if (expect_restart) begin
      check("start_words", 64'(words_loaded), 64'd0);
      check("start_done", 64'(done), 64'd0);
      check("start_err", 64'(err), 64'd0);
    end
  endtask

  task automatic run_load(input logic [15:0] l, input logic [7:0] delta, input bit gaps,
                          input bit poke);
    bit          good_len;
    bit          ok;
    logic [31:0] w;
    good_len = (l != 16'd0) && (l <= 16'd1024);
    ok       = (delta == 8'h00);
    pulse_start(1'b1);
    if (good_len)
      for (int i = 0; i < int'(l); i++) exp_wr.push_back('{addr: 10'(i), data: img[i]});
    send_byte(l[7:0], gaps);
    send_byte(l[15:8], gaps);
    if (!good_len) begin
      check("badlen_err", 64'(err), 64'd1);
      check("badlen_done", 64'(done), 64'd0);
      check("badlen_busy", 64'(busy), 64'd0);
      check("badlen_hold", 64'(cpu_hold), 64'd1);
      check("badlen_words", 64'(words_loaded), 64'd0);
      return;
    end
    for (int i = 0; i < int'(l); i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
      if (poke && i == 0) pulse_start(1'b0);
    end
    send_byte(chk_of(int'(l)) ^ delta, gaps);
    check("end_done", 64'(done), 64'(ok));
    check("end_err", 64'(err), 64'(!ok));
    check("end_busy", 64'(busy), 64'd0);
    check("end_words", 64'(words_loaded), 64'(l));
    check("writes_pending", 64'(exp_wr.size()), 64'd0);
    check("hold_at_end", 64'(cpu_hold), 64'd1);
    @(posedge clk);
    #1;
    check("hold_after_end", 64'(cpu_hold), 64'(!ok));
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_im_wen", 64'(im_wen), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    check("rst_addr", 64'(im_addr), 64'd0);
    check("rst_wdata", 64'(im_wdata), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    #12;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Directed image; the XOR of its eight bytes is 0x2A.
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    check("model_csum", 64'(chk_of(2)), 64'h2A);
    w = img[0];
    check("model_lsb", 64'(w[7:0]), 64'h78);
    run_load(16'd2, 8'h00, 1'b0, 1'b0);

    // rx_valid held high after DONE must not be consumed.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("idle_rx_ready", 64'(rx_ready), 64'd0);
    check("idle_done", 64'(done), 64'd1);
    check("idle_words", 64'(words_loaded), 64'd2);
    rx_valid = 1'b0;

    // Sent checksum byte is 0x2A ^ 0x2B = 0x01.
    run_load(16'd2, 8'h2B, 1'b0, 1'b0);
    run_load(16'h0000, 8'h00, 1'b0, 1'b0);
    run_load(16'h0401, 8'h00, 1'b0, 1'b0);
    run_load(16'd1, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) img[i] = $urandom;
    run_load(16'd3, 8'h00, 1'b0, 1'b0);
    run_load(16'd3, 8'h00, 1'b1, 1'b0);

    // Reset after five data bytes of a 3-word image.
    pulse_start(1'b1);
    exp_wr.push_back('{addr: 10'd0, data: img[0]});
    send_byte(8'd3, 1'b0);
    send_byte(8'd0, 1'b0);
    w = img[0];
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
    w = img[1];
    send_byte(w[7:0], 1'b0);
    check("mid_writes", 64'(exp_wr.size()), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    exp_wr.delete();
    @(negedge clk);
    reset = 1'b1;
    run_load(16'd3, 8'h00, 1'b1, 1'b0);

    // start during DATA is ignored; start in DONE restarts.
    run_load(16'd2, 8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("done_before_restart", 64'(done), 64'd1);
    check("hold_before_restart", 64'(cpu_hold), 64'd0);
    run_load(16'd4, 8'h00, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 12; i++) img[i] = $urandom;
      run_load(16'($urandom_range(1, 12)),
               ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
               1'($urandom_range(0, 1)), 1'b0);
    end

    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    run_load(16'd1024, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
